nios_systemv3_fifo_sum_sq_reader: RTL

NIOS_SYSTEMV3_FIFO_SUM_SQ_READER -- requirements
Module: nios_systemv3_fifo_sum_sq_reader

---
 rtl/nios_systemv3_fifo_sum_sq_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nios_systemv3_fifo_sum_sq_reader.sv
// Sum-of-squares sample FIFO drained by a Nios-style Avalon-MM slave.
// Provides status/control registers and a threshold-based level interrupt.
module nios_systemv3_fifo_sum_sq_reader #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
   localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic [15:0]      threshold_q, threshold_d;
   logic [31:0]      readdata_q, readdata_d;

   logic        rd_s, wr_s, empty_s, full_s;
   logic        push_s, pop_s, flush_s, clear_s, ovf_evt_s, udf_evt_s;
   logic [31:0] head_s, status_s;
   logic        unused_wdata_s;

   assign rd_s     = chipselect & ~read_n;
   assign wr_s     = chipselect & ~write_n;
   assign empty_s  = (count_q == {CW{1'b0}});
   assign full_s   = (count_q == DEPTH_C);
   assign head_s   = 32'(mem_q[rd_ptr_q]);
   assign status_s = {12'h000, underflow_q, overflow_q, full_s, empty_s, 16'(count_q)};

   assign in_ready = ~full_s;
   assign readdata = readdata_q;
   assign irq      = irq_q;
   assign unused_wdata_s = ^writedata[30:16];

   // Next-state: FIFO bookkeeping, sticky flags, control registers, read mux, irq.
   always_comb begin
      flush_s     = wr_s & (address == 2'd2) & writedata[0];
      clear_s     = wr_s & (address == 2'd2) & writedata[1];
      push_s      = in_valid & ~full_s & ~flush_s;
      ovf_evt_s   = in_valid & full_s & ~flush_s;
      pop_s       = rd_s & (address == 2'd0) & ~empty_s;
      udf_evt_s   = rd_s & (address == 2'd0) & empty_s;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      threshold_d = threshold_q;
      irq_en_d    = irq_en_q;
      readdata_d  = readdata_q;

      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
         endcase
      end

      // A fresh event in the same cycle as a clear leaves the flag set.
      if (ovf_evt_s) begin
         overflow_d = 1'b1;
      end else if (clear_s) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      if (udf_evt_s) begin
         underflow_d = 1'b1;
      end else if (clear_s) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end

      if (wr_s && (address == 2'd3)) begin
         threshold_d = writedata[15:0];
         irq_en_d    = writedata[31];
      end else begin
         threshold_d = threshold_q;
         irq_en_d    = irq_en_q;
      end

      if (rd_s) begin
         case (address)
            2'd0:    readdata_d = empty_s ? 32'h0000_0000 : head_s;
            2'd1:    readdata_d = status_s;
            2'd2:    readdata_d = 32'h0000_0000;
            2'd3:    readdata_d = {irq_en_q, 15'h0000, threshold_q};
            default: readdata_d = 32'h0000_0000;
         endcase
      end else begin
         readdata_d = readdata_q;
      end

      irq_d = irq_en_d & (threshold_d != 16'h0000) & (16'(count_d) >= threshold_d);
   end

   // Sample storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (reset_n && push_s) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         threshold_q <= 16'h0000;
         irq_en_q    <= 1'b0;
         readdata_q  <= 32'h0000_0000;
         irq_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         threshold_q <= threshold_d;
         irq_en_q    <= irq_en_d;
         readdata_q  <= readdata_d;
         irq_q       <= irq_d;
      end
   end

endmodule
